// File: rtl/seg7_count_display.sv
// -----------------------------------------------------------------------------
// seg7_count_display
//
// Display stage for a free-running 4-bit counter. It drives a 4-digit,
// common-anode, time-multiplexed 7-segment display:
//   digit 0 : ones digit of the value in decimal
//   digit 1 : tens digit in decimal ("1", or blank when the value is below 10)
//   digit 2 : always blank
//   digit 3 : the value as a single hex character
//
// The counter value is captured into a shadow register once per scan frame, at
// frame start, so all four digits of a frame show the same value and the
// display never tears.
//
// Ports:
//   clk      in   1  system clock, shared with the counter
//   rst_n    in   1  synchronous, active-low reset
//   q_in     in   4  counter value, synchronous to clk
//   ssd      out  8  segment drive {a,b,c,d,e,f,g,dp}, active-low
//   ssd_ctl  out  4  digit enables, active-low, bit 0 = rightmost digit
//
// Parameter:
//   DIGIT_CYCLES  clock cycles each digit stays lit (2 or more)
// -----------------------------------------------------------------------------
module seg7_count_display #(
    parameter int DIGIT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] q_in,
    output logic [7:0] ssd,
    output logic [3:0] ssd_ctl
);

    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(DIGIT_CYCLES - 1);

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_ONE   = 8'h9F;

    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    dig_q,      dig_d;
    logic [3:0]    val_q,      val_d;
    logic [7:0]    ssd_q,      ssd_d;
    logic [3:0]    ssd_ctl_q,  ssd_ctl_d;

    logic          scan_wrap;
    logic          frame_start;
    logic          val_ge_10;
    logic [3:0]    ones;

    // Hex glyphs, active-low, dp off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0:    g = 8'h03;
            4'h1:    g = 8'h9F;
            4'h2:    g = 8'h25;
            4'h3:    g = 8'h0D;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h49;
            4'h6:    g = 8'h41;
            4'h7:    g = 8'h1F;
            4'h8:    g = 8'h01;
            4'h9:    g = 8'h09;
            4'hA:    g = 8'h11;
            4'hB:    g = 8'hC1;
            4'hC:    g = 8'h63;
            4'hD:    g = 8'h85;
            4'hE:    g = 8'h61;
            default: g = 8'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        dig_d       = dig_q;
        val_d       = val_q;
        ssd_d       = GLYPH_BLANK;
        ssd_ctl_d   = 4'b1111;

        scan_wrap   = (scan_cnt_q == SCAN_LAST);
        frame_start = (scan_cnt_q == '0) && (dig_q == 2'd0);

        if (scan_wrap) begin
            scan_cnt_d = '0;
            dig_d      = dig_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        if (frame_start) begin
            val_d = q_in;
        end

        // The value range is 0..15, so the decimal split is a single
        // compare-and-subtract rather than a divider.
        val_ge_10 = (val_d >= 4'd10);
        ones      = val_ge_10 ? (val_d - 4'd10) : val_d;

        // Segment data is built from val_d, not val_q, so the value captured
        // at frame start is already on the first digit-0 cycle of that frame.
        case (dig_q)
            2'd0: begin
                ssd_d     = hex_glyph(ones);
                ssd_ctl_d = 4'b1110;
            end
            2'd1: begin
                ssd_d     = val_ge_10 ? GLYPH_ONE : GLYPH_BLANK;
                ssd_ctl_d = 4'b1101;
            end
            2'd2: begin
                ssd_d     = GLYPH_BLANK;
                ssd_ctl_d = 4'b1011;
            end
            default: begin
                ssd_d     = hex_glyph(val_d);
                ssd_ctl_d = 4'b0111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            dig_q      <= 2'd0;
            val_q      <= 4'd0;
            ssd_q      <= GLYPH_BLANK;
            ssd_ctl_q  <= 4'b1111;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            val_q      <= val_d;
            ssd_q      <= ssd_d;
            ssd_ctl_q  <= ssd_ctl_d;
        end
    end

    assign ssd     = ssd_q;
    assign ssd_ctl = ssd_ctl_q;

endmodule

// File: tb/tb_seg7_count_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_count_display
//
// Directed bench for seg7_count_display with DIGIT_CYCLES = 4 (16-cycle frame).
// Each table record gives the value a frame is expected to show, the four
// expected segment glyphs (digit 3 first), and the cycle within the frame at
// which q_in is moved to the next record's value (which must stay invisible
// until the following frame). Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_count_display;

  localparam int DC    = 4;
  localparam int FRAME = 4 * DC;
  localparam int NVEC  = 14;

  logic       clk;
  logic       rst_n;
  logic [3:0] q_in;
  logic [7:0] ssd;
  logic [3:0] ssd_ctl;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0]      q;
    logic [3:0][7:0] exp;  // {digit3, digit2, digit1, digit0}
    int              chg;  // frame cycle at which q_in moves on (-1: never)
  } vec_t;

  vec_t tbl [NVEC];

  logic [3:0] ctl_exp [4];

  seg7_count_display #(
    .DIGIT_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .q_in   (q_in),
    .ssd    (ssd),
    .ssd_ctl(ssd_ctl)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Checks ncyc cycles of one frame; moves q_in to next_q at cycle v.chg.
  task automatic run_frame(input int fidx, input vec_t v, input logic [3:0] next_q,
                           input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int d;
      d = k / DC;
      @(negedge clk);
      check($sformatf("frame%0d q=%0d dig%0d cyc%0d ssd_ctl", fidx, v.q, d, k % DC),
            {4'b0, ssd_ctl}, {4'b0, ctl_exp[d]});
      check($sformatf("frame%0d q=%0d dig%0d cyc%0d ssd", fidx, v.q, d, k % DC),
            ssd, v.exp[d]);
      if (k == v.chg) q_in = next_q;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t mid;
    vec_t after_rst;

    n_cmp = 0;
    n_bad = 0;

    ctl_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    //             q      {dig3,  dig2,  dig1,  dig0}            chg
    tbl[0]  = '{4'd0,  {8'h03, 8'hFF, 8'hFF, 8'h03}, 15};
    tbl[1]  = '{4'd7,  {8'h1F, 8'hFF, 8'hFF, 8'h1F}, 6};
    tbl[2]  = '{4'd13, {8'h85, 8'hFF, 8'h9F, 8'h0D}, 15};
    tbl[3]  = '{4'd5,  {8'h49, 8'hFF, 8'hFF, 8'h49}, 5};   // change while dig=1
    tbl[4]  = '{4'd12, {8'h63, 8'hFF, 8'h9F, 8'h25}, 15};
    tbl[5]  = '{4'd15, {8'h71, 8'hFF, 8'h9F, 8'h49}, 12};  // 15 -> 0 wrap
    tbl[6]  = '{4'd0,  {8'h03, 8'hFF, 8'hFF, 8'h03}, 0};
    tbl[7]  = '{4'd9,  {8'h09, 8'hFF, 8'hFF, 8'h09}, 10};
    tbl[8]  = '{4'd10, {8'h11, 8'hFF, 8'h9F, 8'h03}, 3};
    tbl[9]  = '{4'd11, {8'hC1, 8'hFF, 8'h9F, 8'h9F}, 15};
    tbl[10] = '{4'd4,  {8'h99, 8'hFF, 8'hFF, 8'h99}, 7};
    tbl[11] = '{4'd14, {8'h61, 8'hFF, 8'h9F, 8'h99}, 15};
    tbl[12] = '{4'd8,  {8'h01, 8'hFF, 8'hFF, 8'h01}, 1};
    tbl[13] = '{4'd3,  {8'h0D, 8'hFF, 8'hFF, 8'h0D}, -1};

    // Reset asserted: outputs blank, all digits off.
    rst_n = 1'b0;
    q_in  = tbl[0].q;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ssd", ssd, 8'hFF);
    check("reset ssd_ctl", {4'b0, ssd_ctl}, 8'h0F);
    rst_n = 1'b1;  // next rising edge is frame start

    for (int i = 0; i < NVEC; i++) begin
      run_frame(i, tbl[i], (i + 1 < NVEC) ? tbl[i + 1].q : tbl[i].q, FRAME);
    end

    // Reset mid-scan: the frame showing 3 is cut after the first cycle of
    // digit 2 (internal dig=2, scan_cnt=1 at that point).
    mid     = tbl[NVEC - 1];
    mid.chg = -1;
    run_frame(NVEC, mid, mid.q, 2 * DC + 1);
    rst_n = 1'b0;
    q_in  = 4'd6;
    @(negedge clk);
    check("midscan reset ssd", ssd, 8'hFF);
    check("midscan reset ssd_ctl", {4'b0, ssd_ctl}, 8'h0F);
    rst_n = 1'b1;

    // Scanning restarts at digit 0 with a full dwell, showing the new value.
    after_rst = '{4'd6, {8'h41, 8'hFF, 8'hFF, 8'h41}, -1};
    run_frame(NVEC + 1, after_rst, 4'd6, FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
